// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS systolic matrix multiplier with built-in input skew
// and a row-at-a-time result drain. C = A(ROWS x K) * B(K x COLS), one k-beat per handshake.
`timescale 1ns/1ps
module systolic_array_os #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_last,
  input  logic [ROWS*DATA_W-1:0]                   a_col,
  input  logic [COLS*DATA_W-1:0]                   b_row,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [COLS*ACC_W-1:0]                    out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                     out_last,
  output logic                                     busy
);

  localparam int PW      = 2 * DATA_W;
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW      = $clog2(ROWS + COLS);
  localparam int FLUSH_N = ROWS + COLS - 2;

  generate
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $error("systolic_array_os: ACC_W must be at least 2*DATA_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            hs_in;
  logic            drain_done;

  logic [ROWS*DATA_W-1:0] a_inj;
  logic [COLS*DATA_W-1:0] b_inj;
  logic [DATA_W-1:0]      a_skew [ROWS];
  logic [DATA_W-1:0]      b_skew [COLS];

  logic [DATA_W-1:0] a_in   [ROWS][COLS];
  logic [DATA_W-1:0] b_in   [ROWS][COLS];
  logic [DATA_W-1:0] a_q    [ROWS][COLS-1];
  logic [DATA_W-1:0] a_d    [ROWS][COLS-1];
  logic [DATA_W-1:0] b_q    [ROWS-1][COLS];
  logic [DATA_W-1:0] b_d    [ROWS-1][COLS];
  logic [ACC_W-1:0]  prod_q [ROWS][COLS];
  logic [ACC_W-1:0]  prod_d [ROWS][COLS];
  logic [ACC_W-1:0]  acc_q  [ROWS][COLS];
  logic [ACC_W-1:0]  acc_d  [ROWS][COLS];

  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic signed [PW-1:0] ps;
    logic        [PW-1:0] pu;
    ps = PW'($signed(a)) * PW'($signed(b));
    pu = PW'(a) * PW'(b);
    if (SIGNED) mul_ext = ACC_W'(ps);
    else        mul_ext = ACC_W'(pu);
  endfunction

  assign in_ready   = (state_q == S_LOAD);
  assign out_valid  = (state_q == S_DRAIN);
  assign busy       = (state_q != S_LOAD);
  assign out_row    = row_q;
  assign out_last   = out_valid && (row_q == RW'(ROWS - 1));
  assign hs_in      = in_valid && in_ready;
  assign drain_done = out_valid && out_ready && (row_q == RW'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    unique case (state_q)
      S_LOAD: begin
        if (hs_in && in_last) begin
          state_d = S_FLUSH;
          cnt_d   = CW'(FLUSH_N);
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_DRAIN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = S_LOAD;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Injection: idle cycles feed zeros so they never disturb the running sums.
  assign a_inj = hs_in ? a_col : '0;
  assign b_inj = hs_in ? b_row : '0;

  // Skew stage: lane n of A and B is delayed by n registers.
  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
      if (gi == 0) begin : g_direct
        assign a_skew[gi] = a_inj[DATA_W-1:0];
      end else begin : g_dly
        logic [DATA_W-1:0] sk_q [gi];
        logic [DATA_W-1:0] sk_d [gi];
        always_comb begin
          sk_d[0] = a_inj[gi*DATA_W +: DATA_W];
          for (int m = 1; m < gi; m++) sk_d[m] = sk_q[m-1];
        end
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int m = 0; m < gi; m++) sk_q[m] <= '0;
          end else begin
            for (int m = 0; m < gi; m++) sk_q[m] <= sk_d[m];
          end
        end
        assign a_skew[gi] = sk_q[gi-1];
      end
    end

    for (gj = 0; gj < COLS; gj++) begin : g_b_skew
      if (gj == 0) begin : g_direct
        assign b_skew[gj] = b_inj[DATA_W-1:0];
      end else begin : g_dly
        logic [DATA_W-1:0] sk_q [gj];
        logic [DATA_W-1:0] sk_d [gj];
        always_comb begin
          sk_d[0] = b_inj[gj*DATA_W +: DATA_W];
          for (int m = 1; m < gj; m++) sk_d[m] = sk_q[m-1];
        end
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int m = 0; m < gj; m++) sk_q[m] <= '0;
          end else begin
            for (int m = 0; m < gj; m++) sk_q[m] <= sk_d[m];
          end
        end
        assign b_skew[gj] = sk_q[gj-1];
      end
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_pe_row
      for (gj = 0; gj < COLS; gj++) begin : g_pe_col
        if (gj == 0) begin : g_a_edge
          assign a_in[gi][gj] = a_skew[gi];
        end else begin : g_a_int
          assign a_in[gi][gj] = a_q[gi][gj-1];
        end
        if (gi == 0) begin : g_b_edge
          assign b_in[gi][gj] = b_skew[gj];
        end else begin : g_b_int
          assign b_in[gi][gj] = b_q[gi-1][gj];
        end
      end
    end
  endgenerate

  // PE stage: operands forward right/down, product is registered, then accumulated.
  always_comb begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS - 1; c++)
        a_d[r][c] = a_in[r][c];
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++)
        b_d[r][c] = b_in[r][c];
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod_d[r][c] = mul_ext(a_in[r][c], b_in[r][c]);
        acc_d[r][c]  = drain_done ? '0 : acc_q[r][c] + prod_q[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS - 1; c++)
          a_q[r][c] <= '0;
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          b_q[r][c] <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          prod_q[r][c] <= '0;
          acc_q[r][c]  <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS - 1; c++)
          a_q[r][c] <= a_d[r][c];
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          b_q[r][c] <= b_d[r][c];
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          prod_q[r][c] <= prod_d[r][c];
          acc_q[r][c]  <= acc_d[r][c];
        end
      end
    end
  end

  // Drain stage: the selected accumulator row is presented as-is.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++)
      out_data[c*ACC_W +: ACC_W] = acc_q[row_q][c];
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os: three instances (signed/32, unsigned/32,
// unsigned/16) share stimulus so each directed matrix checks every arithmetic mode.
`timescale 1ns/1ps
module tb_systolic_array_os;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid, in_last, out_ready;
  logic [R*DW-1:0] a_col;
  logic [C*DW-1:0] b_row;

  logic ir0, ir1, ir2, ov0, ov1, ov2, ol0, ol1, ol2, bz0, bz1, bz2;
  logic [1:0] orow0, orow1, orow2;
  logic [C*32-1:0] od0, od1;
  logic [C*16-1:0] od2;

  systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(32), .SIGNED(1'b1)) u_s32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .in_last(in_last),
    .a_col(a_col), .b_row(b_row), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_row(orow0), .out_last(ol0), .busy(bz0));

  systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(32), .SIGNED(1'b0)) u_u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_last(in_last),
    .a_col(a_col), .b_row(b_row), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_row(orow1), .out_last(ol1), .busy(bz1));

  systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(16), .SIGNED(1'b0)) u_u16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .in_last(in_last),
    .a_col(a_col), .b_row(b_row), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_row(orow2), .out_last(ol2), .busy(bz2));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] e0 [R][C];
  logic [31:0] e1 [R][C];
  logic [31:0] e2 [R][C];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rep(input logic [7:0] x);
    return {4{x}};
  endfunction

  // Identity A: beat k carries a 1 only in lane k.
  function automatic logic [31:0] t1_a(input int k);
    logic [31:0] a;
    a = '0;
    a[k*8 +: 8] = 8'd1;
    return a;
  endfunction

  function automatic logic [31:0] t1_b(input int k);
    logic [31:0] b;
    for (int j = 0; j < C; j++) b[j*8 +: 8] = 8'(4*k + j + 1);
    return b;
  endfunction

  task automatic set_exp(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    for (int r = 0; r < R; r++)
      for (int j = 0; j < C; j++) begin
        e0[r][j] = v0; e1[r][j] = v1; e2[r][j] = v2;
      end
  endtask

  task automatic set_exp_t1();
    for (int r = 0; r < R; r++)
      for (int j = 0; j < C; j++) begin
        e0[r][j] = 32'(4*r + j + 1); e1[r][j] = e0[r][j]; e2[r][j] = e0[r][j];
      end
  endtask

  task automatic beat(input logic v, input logic last, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; in_last = last; a_col = a; b_row = b;
    @(posedge clk); #1;
  endtask

  task automatic feed_t1(input bit bubbles);
    for (int k = 0; k < 4; k++) begin
      if (bubbles && k > 0) begin
        beat(1'b0, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
        beat(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      end
      beat(1'b1, k == 3, t1_a(k), t1_b(k));
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    in_valid = 1'b0; in_last = 1'b0;
    while (ov0 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_row(input int r, input string tag);
    check({tag, "_ov"}, {ov2, ov1, ov0}, 3'b111);
    check({tag, "_row"}, orow0, 64'(r));
    check({tag, "_row_all"}, {orow2 == orow0, orow1 == orow0}, 2'b11);
    check({tag, "_last"}, {ol2, ol1, ol0}, (r == R-1) ? 3'b111 : 3'b000);
    for (int j = 0; j < C; j++) begin
      check({tag, "_s32"}, od0[j*32 +: 32], e0[r][j]);
      check({tag, "_u32"}, od1[j*32 +: 32], e1[r][j]);
      check({tag, "_u16"}, od2[j*16 +: 16], 64'(e2[r][j][15:0]));
    end
  endtask

  task automatic drain(input int stall, input string tag);
    for (int r = 0; r < R; r++) begin
      repeat (stall) begin
        out_ready = 1'b0;
        check_row(r, {tag, "_hold"});
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      check_row(r, tag);
      @(posedge clk); #1;
    end
    check({tag, "_ir_after"}, {ir2, ir1, ir0}, 3'b111);
    check({tag, "_ov_after"}, {ov2, ov1, ov0}, 3'b000);
    check({tag, "_busy_after"}, {bz2, bz1, bz0}, 3'b000);
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_ir"}, {ir2, ir1, ir0}, 3'b111);
    check({tag, "_ov"}, {ov2, ov1, ov0}, 3'b000);
    check({tag, "_busy"}, {bz2, bz1, bz0}, 3'b000);
    check({tag, "_last"}, {ol2, ol1, ol0}, 3'b000);
    check({tag, "_row"}, {orow2, orow1, orow0}, 6'd0);
    check({tag, "_data"}, {od0 == '0, od1 == '0, od2 == '0}, 3'b111);
  endtask

  task automatic run_k1_ones(input string tag);
    int n;
    set_exp(32'd1, 32'd1, 32'd1);
    beat(1'b1, 1'b1, rep(8'd1), rep(8'd1));
    wait_out(n);
    check({tag, "_lat"}, n, 64'd7);
    drain(0, tag);
  endtask

  initial begin
    int n;
    in_valid = 1'b0; in_last = 1'b0; a_col = '0; b_row = '0; out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_rst("rst0");
    reset = 1'b0;
    @(posedge clk); #1;

    // Identity times counting matrix, latency and ordering.
    set_exp_t1();
    feed_t1(1'b0);
    check("t1_busy_flush", {bz0, ir0}, 2'b10);
    wait_out(n);
    check("t1_lat", n, 64'd7);
    drain(0, "t1");

    // Signed extremes: -128 * -128 * 3.
    set_exp(32'd49152, 32'd49152, 32'd49152);
    for (int k = 0; k < 3; k++) beat(1'b1, k == 2, rep(8'h80), rep(8'h80));
    wait_out(n);
    check("t2a_lat", n, 64'd7);
    drain(0, "t2a");

    // All 0xFF, K=3: -1*-1*3 signed, 65025*3 unsigned, mod 2^16 on the narrow one.
    set_exp(32'd3, 32'd195075, 32'd64003);
    for (int k = 0; k < 3; k++) beat(1'b1, k == 2, rep(8'hFF), rep(8'hFF));
    wait_out(n);
    check("t2b_lat", n, 64'd7);
    drain(0, "t2b");

    // Wrap, K=2: 130050 mod 65536 = 64514.
    set_exp(32'd2, 32'd130050, 32'd64514);
    for (int k = 0; k < 2; k++) beat(1'b1, k == 1, rep(8'hFF), rep(8'hFF));
    wait_out(n);
    check("t5_lat", n, 64'd7);
    drain(0, "t5");

    // Bubbles (with junk data and a stray in_last) and 3-cycle stalls per row.
    set_exp_t1();
    feed_t1(1'b1);
    wait_out(n);
    check("t3_lat", n, 64'd7);
    drain(3, "t3");

    // K=1, then a back-to-back matrix in the very next LOAD cycle.
    set_exp(32'd6, 32'd6, 32'd6);
    beat(1'b1, 1'b1, rep(8'd2), rep(8'd3));
    wait_out(n);
    check("t4a_lat", n, 64'd7);
    drain(0, "t4a");
    set_exp(32'd5, 32'd5, 32'd5);
    beat(1'b1, 1'b1, rep(8'd1), rep(8'd5));
    wait_out(n);
    check("t4b_lat", n, 64'd7);
    drain(0, "t4b");

    // Asynchronous reset in FLUSH.
    beat(1'b1, 1'b0, rep(8'd7), rep(8'd9));
    beat(1'b1, 1'b1, rep(8'd7), rep(8'd9));
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    check("t6a_busy", bz0, 1'b1);
    reset = 1'b1;
    #1;
    chk_rst("rst_flush");
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run_k1_ones("t6a");

    // Asynchronous reset in DRAIN after one row has gone out.
    beat(1'b1, 1'b1, rep(8'd2), rep(8'd3));
    wait_out(n);
    check("t6b_ov", ov0, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t6b_row1", orow0, 64'd1);
    reset = 1'b1;
    #1;
    chk_rst("rst_drain");
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run_k1_ones("t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
